// File: rtl/ficonv_mod.sv
// ficonv_mod: pipelined float-to-integer converter for the FP math unit.
// Converts one packed 82-bit sngl/dbl/ext operand to a 64-bit signed or unsigned
// integer and raises the invalid and inexact flags.
// Pipeline: input capture -> unpack -> shift -> round/negate/saturate (result register).
// All stages advance only when clkEn=1.
// Optional feature: define FICONV_RNDMODE_EN to add the rnd[1:0] rounding-mode input.
// Without it, conversion always truncates toward zero.
module ficonv_mod #(
  parameter logic [63:0] INDEF = 64'h8000_0000_0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clkEn,
  input  logic [81:0] A,
  input  logic        fromSNG,
  input  logic        fromDBL,
  input  logic        fromEXT,
  input  logic        isS,
`ifdef FICONV_RNDMODE_EN
  input  logic [1:0]  rnd,
`endif
  output logic [64:0] res,
  output logic        invalid,
  output logic        inexact,
  output logic        alt
);

  typedef enum logic [1:0] {
    RndNearEven = 2'd0,
    RndDown     = 2'd1,
    RndUp       = 2'd2,
    RndZero     = 2'd3
  } rnd_e;

  localparam logic [64:0] TwoPow63 = 65'h0_8000_0000_0000_0000;

  rnd_e rnd_mode;

`ifdef FICONV_RNDMODE_EN
  assign rnd_mode = rnd_e'(rnd);
`else
  assign rnd_mode = RndZero;
`endif

  // ---------------------------------------------------------------------------
  // Stage 0: capture the operand together with its mode bits
  // ---------------------------------------------------------------------------
  logic        s0_vld;
  logic [81:0] s0_a;
  logic [2:0]  s0_fmt;
  logic        s0_iss;
  rnd_e        s0_rnd;

  // Capture register; mode bits travel alongside the operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_vld <= 1'b0;
      s0_a   <= '0;
      s0_fmt <= '0;
      s0_iss <= 1'b0;
      s0_rnd <= RndZero;
    end else if (clkEn) begin
      s0_vld <= en;
      s0_a   <= A;
      s0_fmt <= {fromSNG, fromDBL, fromEXT};
      s0_iss <= isS;
      s0_rnd <= rnd_mode;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: unpack fields, unbias the exponent, classify the operand
  // ---------------------------------------------------------------------------
  logic [14:0]        u_exp;
  logic signed [16:0] u_bias;
  logic signed [16:0] u_unb;
  logic signed [16:0] u_sh_s;
  logic               u_x;
  logic               u_sign;
  logic               u_none;
  logic               u_fzero;
  logic               u_eones;
  logic [63:0]        u_man;
  logic               u_zero;
  logic               u_nan;
  logic               u_big;
  logic               u_tiny;

  // Field extraction per layout; stored exponent msb is inverted w.r.t. IEEE.
  always_comb begin
    u_exp   = '0;
    u_bias  = '0;
    u_x     = 1'b0;
    u_sign  = 1'b0;
    u_none  = 1'b0;
    u_fzero = 1'b0;
    u_eones = 1'b0;
    u_man   = '0;
    unique case (s0_fmt)
      3'b100: begin
        u_x     = s0_a[32];
        u_sign  = s0_a[31];
        u_exp   = {7'd0, ~s0_a[30], s0_a[29:23]};
        u_fzero = (s0_a[30:23] == 8'd0);
        u_eones = (u_exp[7:0] == 8'hFF);
        u_bias  = 17'sd127;
        u_man   = {1'b1, s0_a[22:0], 40'd0};
      end
      3'b010: begin
        // A[32] is a gap bit in the dbl layout and is ignored.
        u_x     = s0_a[65];
        u_sign  = s0_a[64];
        u_exp   = {4'd0, ~s0_a[63], s0_a[62:53]};
        u_fzero = (s0_a[63:53] == 11'd0);
        u_eones = (u_exp[10:0] == 11'h7FF);
        u_bias  = 17'sd1023;
        u_man   = {1'b1, s0_a[52:33], s0_a[31:0], 11'd0};
      end
      3'b001: begin
        // ext carries an explicit integer bit in the mantissa.
        u_sign  = s0_a[81];
        u_exp   = {~s0_a[80], s0_a[79:66]};
        u_x     = s0_a[65];
        u_fzero = (s0_a[80:66] == 15'd0);
        u_eones = &u_exp;
        u_bias  = 17'sd16383;
        u_man   = {s0_a[64:33], s0_a[31:0]};
      end
      default: u_none = 1'b1;
    endcase
    u_unb  = $signed({2'b00, u_exp}) - u_bias;
    // Right-shift distance that brings the binary point to bit 0.
    u_sh_s = 17'sd63 - u_unb;
  end

  // Operand class; zero also covers "no format selected".
  always_comb begin
    u_zero = u_none | (~u_x & u_fzero);
    u_nan  = ~u_none & u_x & u_eones;
    u_big  = (u_unb > 17'sd63);
    u_tiny = (u_unb < -17'sd1);
  end

  logic        s1_vld;
  logic        s1_sign;
  logic        s1_iss;
  rnd_e        s1_rnd;
  logic        s1_zero;
  logic        s1_bad;
  logic        s1_tiny;
  logic [6:0]  s1_sh;
  logic [63:0] s1_man;

  // Unpack register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_iss  <= 1'b0;
      s1_rnd  <= RndZero;
      s1_zero <= 1'b0;
      s1_bad  <= 1'b0;
      s1_tiny <= 1'b0;
      s1_sh   <= '0;
      s1_man  <= '0;
    end else if (clkEn) begin
      s1_vld  <= s0_vld;
      s1_sign <= u_sign;
      s1_iss  <= s0_iss;
      s1_rnd  <= s0_rnd;
      s1_zero <= u_zero;
      s1_bad  <= ~u_zero & (u_nan | u_big);
      s1_tiny <= u_tiny;
      s1_sh   <= u_sh_s[6:0];
      s1_man  <= u_man;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: align mantissa, extract integer magnitude, guard and sticky
  // ---------------------------------------------------------------------------
  logic [127:0] sh_wide;
  logic [63:0]  sh_mag;
  logic         sh_guard;
  logic         sh_sticky;

  // Shift {man, 0} so the upper half is the integer and the lower half the fraction.
  always_comb begin
    sh_wide   = {s1_man, 64'd0} >> s1_sh;
    sh_mag    = sh_wide[127:64];
    sh_guard  = sh_wide[63];
    sh_sticky = |sh_wide[62:0];
    if (s1_zero) begin
      sh_mag    = '0;
      sh_guard  = 1'b0;
      sh_sticky = 1'b0;
    end else if (s1_tiny) begin
      // |value| < 0.5: everything lands in the sticky bit.
      sh_mag    = '0;
      sh_guard  = 1'b0;
      sh_sticky = |s1_man;
    end
  end

  logic        s2_vld;
  logic        s2_sign;
  logic        s2_iss;
  rnd_e        s2_rnd;
  logic        s2_zero;
  logic        s2_bad;
  logic [63:0] s2_mag;
  logic        s2_guard;
  logic        s2_sticky;

  // Shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld    <= 1'b0;
      s2_sign   <= 1'b0;
      s2_iss    <= 1'b0;
      s2_rnd    <= RndZero;
      s2_zero   <= 1'b0;
      s2_bad    <= 1'b0;
      s2_mag    <= '0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
    end else if (clkEn) begin
      s2_vld    <= s1_vld;
      s2_sign   <= s1_sign;
      s2_iss    <= s1_iss;
      s2_rnd    <= s1_rnd;
      s2_zero   <= s1_zero;
      s2_bad    <= s1_bad;
      s2_mag    <= sh_mag;
      s2_guard  <= sh_guard;
      s2_sticky <= sh_sticky;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: round, range-check, negate, saturate to INDEF
  // ---------------------------------------------------------------------------
  logic        rc_inc;
  logic [64:0] rc_mag;
  logic        rc_oor;
  logic [63:0] rc_val;
  logic [64:0] rc_res;
  logic        rc_inv;
  logic        rc_inx;

  // Rounding increment from guard/sticky; toward-zero never increments.
  always_comb begin
    rc_inc = 1'b0;
    case (s2_rnd)
      RndNearEven: rc_inc = s2_guard & (s2_sticky | s2_mag[0]);
      RndDown:     rc_inc = s2_sign & (s2_guard | s2_sticky);
      RndUp:       rc_inc = ~s2_sign & (s2_guard | s2_sticky);
      default:     rc_inc = 1'b0;
    endcase
  end

  // Range check on the rounded magnitude (65 bits so a carry-out is visible).
  always_comb begin
    rc_mag = {1'b0, s2_mag} + 65'(rc_inc);
    if (s2_iss) begin
      rc_oor = s2_sign ? (rc_mag > TwoPow63) : (rc_mag >= TwoPow63);
    end else begin
      // Negative values that truncate to zero stay legal.
      rc_oor = rc_mag[64] | (s2_sign & (|rc_mag));
    end
    rc_val = s2_sign ? (~rc_mag[63:0] + 64'd1) : rc_mag[63:0];
  end

  // Final result selection; bit 64 mirrors bit 63 only for signed results.
  always_comb begin
    rc_res = '0;
    rc_inv = 1'b0;
    rc_inx = 1'b0;
    if (s2_zero) begin
      rc_res = '0;
    end else if (s2_bad | rc_oor) begin
      rc_inv = 1'b1;
      rc_res = {s2_iss & INDEF[63], INDEF};
    end else begin
      rc_inx = s2_guard | s2_sticky;
      rc_res = {s2_iss & rc_val[63], rc_val};
    end
  end

  // Result register; alt pulses only after an advancing edge that retires an op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alt     <= 1'b0;
      res     <= '0;
      invalid <= 1'b0;
      inexact <= 1'b0;
    end else begin
      alt <= clkEn & s2_vld;
      if (clkEn && s2_vld) begin
        res     <= rc_res;
        invalid <= rc_inv;
        inexact <= rc_inx;
      end
    end
  end

endmodule

// File: tb/tb_ficonv_mod.sv
// tb_ficonv_mod: directed-vector bench for ficonv_mod with hand-computed expectations.
// Covers reset, all three layouts, zero/NaN/Inf, range limits, stalls and mid-flight reset.
// With FICONV_RNDMODE_EN defined it also checks the rounding modes.
module tb_ficonv_mod;

  localparam logic [2:0] FmtS = 3'b100;
  localparam logic [2:0] FmtD = 3'b010;
  localparam logic [2:0] FmtE = 3'b001;
  localparam logic [2:0] FmtN = 3'b000;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clkEn;
  logic [81:0] A;
  logic        fromSNG;
  logic        fromDBL;
  logic        fromEXT;
  logic        isS;
`ifdef FICONV_RNDMODE_EN
  logic [1:0]  rnd;
`endif
  logic [64:0] res;
  logic        invalid;
  logic        inexact;
  logic        alt;

  int n_tot = 0;
  int n_bad = 0;

  ficonv_mod dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clkEn   (clkEn),
    .A       (A),
    .fromSNG (fromSNG),
    .fromDBL (fromDBL),
    .fromEXT (fromEXT),
    .isS     (isS),
`ifdef FICONV_RNDMODE_EN
    .rnd     (rnd),
`endif
    .res     (res),
    .invalid (invalid),
    .inexact (inexact),
    .alt     (alt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [81:0] pk_sng(input logic x, input logic s, input logic [7:0] f,
                                         input logic [22:0] fr);
    logic [81:0] a;
    a = '0;
    a[32] = x;
    a[31] = s;
    a[30:23] = f;
    a[22:0] = fr;
    return a;
  endfunction

  // Gap bit A[32] set on purpose: it must be ignored.
  function automatic logic [81:0] pk_dbl(input logic x, input logic s, input logic [10:0] f,
                                         input logic [51:0] fr);
    logic [81:0] a;
    a = '0;
    a[65] = x;
    a[64] = s;
    a[63:53] = f;
    a[52:33] = fr[51:32];
    a[32] = 1'b1;
    a[31:0] = fr[31:0];
    return a;
  endfunction

  function automatic logic [81:0] pk_ext(input logic s, input logic [14:0] f, input logic x,
                                         input logic [63:0] m);
    logic [81:0] a;
    a = '0;
    a[81] = s;
    a[80:66] = f;
    a[65] = x;
    a[64:33] = m[63:32];
    a[31:0] = m[31:0];
    return a;
  endfunction

  task automatic set_in(input logic [81:0] a, input logic [2:0] fmt, input logic s);
    A = a;
    {fromSNG, fromDBL, fromEXT} = fmt;
    isS = s;
  endtask

  // One isolated op: checks latency (3 advancing edges), result, flags, single-cycle alt.
  task automatic run_op(input string tag, input logic [81:0] a, input logic [2:0] fmt,
                        input logic s, input logic [64:0] er, input logic ei, input logic ex);
    int lat;
    @(negedge clk);
    set_in(a, fmt, s);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    // Scramble inputs so only the captured copy can produce the result.
    set_in('1, 3'b001, ~s);
    lat = 0;
    while (alt !== 1'b1 && lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_val({tag, " latency"}, 65'(lat), 65'd3);
    check_val({tag, " res"}, res, er);
    check_val({tag, " invalid"}, 65'(invalid), 65'(ei));
    check_val({tag, " inexact"}, 65'(inexact), 65'(ex));
    @(negedge clk);
    check_val({tag, " alt pulse"}, 65'(alt), 65'd0);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    en = 1'b0;
    clkEn = 1'b1;
    set_in('0, FmtN, 1'b0);
`ifdef FICONV_RNDMODE_EN
    rnd = 2'd3;
`endif
    repeat (2) @(negedge clk);
    check_val("reset alt", 65'(alt), 65'd0);
    check_val("reset res", res, 65'd0);
    check_val("reset invalid", 65'(invalid), 65'd0);
    check_val("reset inexact", 65'(inexact), 65'd0);
    rst = 1'b0;

    run_op("dbl 1.0", pk_dbl(1'b0, 1'b0, 11'h7FF, 52'h0), FmtD, 1'b1,
           65'h0_0000_0000_0000_0001, 1'b0, 1'b0);
    run_op("sng -2.5", pk_sng(1'b1, 1'b1, 8'h00, 23'h200000), FmtS, 1'b1,
           65'h1_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
    run_op("ext 2^63 u", pk_ext(1'b0, 15'h003E, 1'b1, 64'h8000_0000_0000_0000), FmtE, 1'b0,
           65'h0_8000_0000_0000_0000, 1'b0, 1'b0);
    run_op("ext 2^63 s", pk_ext(1'b0, 15'h003E, 1'b1, 64'h8000_0000_0000_0000), FmtE, 1'b1,
           65'h1_8000_0000_0000_0000, 1'b1, 1'b0);
    run_op("ext -2^63 s", pk_ext(1'b1, 15'h003E, 1'b1, 64'h8000_0000_0000_0000), FmtE, 1'b1,
           65'h1_8000_0000_0000_0000, 1'b0, 1'b0);
    run_op("ext umax", pk_ext(1'b0, 15'h003E, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF), FmtE, 1'b0,
           65'h0_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op("ext 2^64", pk_ext(1'b0, 15'h003F, 1'b1, 64'h8000_0000_0000_0000), FmtE, 1'b0,
           65'h0_8000_0000_0000_0000, 1'b1, 1'b0);
    run_op("dbl nan", pk_dbl(1'b1, 1'b0, 11'h3FF, 52'h1), FmtD, 1'b1,
           65'h1_8000_0000_0000_0000, 1'b1, 1'b0);
    run_op("sng inf", pk_sng(1'b1, 1'b0, 8'h7F, 23'h0), FmtS, 1'b0,
           65'h0_8000_0000_0000_0000, 1'b1, 1'b0);
    run_op("ext zero", pk_ext(1'b0, 15'h0000, 1'b0, 64'h0000_0000_0000_1234), FmtE, 1'b1,
           65'h0, 1'b0, 1'b0);
    run_op("dbl -0.5 u", pk_dbl(1'b0, 1'b1, 11'h7FE, 52'h0), FmtD, 1'b0,
           65'h0, 1'b0, 1'b1);
    run_op("dbl -1.0 u", pk_dbl(1'b0, 1'b1, 11'h7FF, 52'h0), FmtD, 1'b0,
           65'h0_8000_0000_0000_0000, 1'b1, 1'b0);
    run_op("sng 0.25", pk_sng(1'b0, 1'b0, 8'hFD, 23'h0), FmtS, 1'b1,
           65'h0, 1'b0, 1'b1);
    run_op("dbl -1234", pk_dbl(1'b1, 1'b1, 11'h009, 52'h3_4800_0000_0000), FmtD, 1'b1,
           65'h1_FFFF_FFFF_FFFF_FB2E, 1'b0, 1'b0);
    run_op("no fmt", pk_dbl(1'b0, 1'b0, 11'h7FF, 52'h0), FmtN, 1'b1,
           65'h0, 1'b0, 1'b0);

`ifdef FICONV_RNDMODE_EN
    rnd = 2'd0;
    run_op("rne 2.5", pk_dbl(1'b1, 1'b0, 11'h000, 52'h4_0000_0000_0000), FmtD, 1'b1,
           65'h0_0000_0000_0000_0002, 1'b0, 1'b1);
    rnd = 2'd2;
    run_op("up 2.5", pk_dbl(1'b1, 1'b0, 11'h000, 52'h4_0000_0000_0000), FmtD, 1'b1,
           65'h0_0000_0000_0000_0003, 1'b0, 1'b1);
    rnd = 2'd1;
    run_op("down -2.5", pk_dbl(1'b1, 1'b1, 11'h000, 52'h4_0000_0000_0000), FmtD, 1'b1,
           65'h1_FFFF_FFFF_FFFF_FFFD, 1'b0, 1'b1);
    rnd = 2'd2;
    run_op("up umax ovf", pk_ext(1'b0, 15'h003E, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF), FmtE, 1'b0,
           65'h0_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    rnd = 2'd3;
`endif

    // Back-to-back ops with a two-cycle stall while all three are in flight.
    @(negedge clk);
    set_in(pk_dbl(1'b0, 1'b0, 11'h7FF, 52'h0), FmtD, 1'b1);
    en = 1'b1;
    @(negedge clk);
    set_in(pk_sng(1'b1, 1'b1, 8'h00, 23'h200000), FmtS, 1'b1);
    @(negedge clk);
    set_in(pk_dbl(1'b1, 1'b1, 11'h009, 52'h3_4800_0000_0000), FmtD, 1'b1);
    @(negedge clk);
    en = 1'b0;
    clkEn = 1'b0;
    set_in('1, FmtE, 1'b0);
    @(negedge clk);
    check_val("stall alt 0", 65'(alt), 65'd0);
    @(negedge clk);
    check_val("stall alt 1", 65'(alt), 65'd0);
    clkEn = 1'b1;
    @(negedge clk);
    check_val("b2b op1 alt", 65'(alt), 65'd1);
    check_val("b2b op1 res", res, 65'h0_0000_0000_0000_0001);
    @(negedge clk);
    check_val("b2b op2 alt", 65'(alt), 65'd1);
    check_val("b2b op2 res", res, 65'h1_FFFF_FFFF_FFFF_FFFE);
    check_val("b2b op2 inexact", 65'(inexact), 65'd1);
    @(negedge clk);
    check_val("b2b op3 alt", 65'(alt), 65'd1);
    check_val("b2b op3 res", res, 65'h1_FFFF_FFFF_FFFF_FB2E);
    check_val("b2b op3 inexact", 65'(inexact), 65'd0);
    @(negedge clk);
    check_val("b2b drain alt", 65'(alt), 65'd0);

    // Reset while a result is showing and another op is in flight.
    @(negedge clk);
    set_in(pk_dbl(1'b0, 1'b0, 11'h7FF, 52'h0), FmtD, 1'b1);
    en = 1'b1;
    @(negedge clk);
    set_in(pk_dbl(1'b1, 1'b1, 11'h009, 52'h3_4800_0000_0000), FmtD, 1'b1);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("pre-rst alt", 65'(alt), 65'd1);
    check_val("pre-rst res", res, 65'h0_0000_0000_0000_0001);
    #2 rst = 1'b1;
    #1;
    check_val("rst async alt", 65'(alt), 65'd0);
    check_val("rst async res", res, 65'd0);
    check_val("rst async flags", 65'({invalid, inexact}), 65'd0);
    // en held high across an edge during reset must be dropped.
    @(negedge clk);
    set_in(pk_dbl(1'b1, 1'b0, 11'h3FF, 52'h1), FmtD, 1'b1);
    en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (alt === 1'b1) cnt++;
    end
    check_val("no stale alt", 65'(cnt), 65'd0);
    check_val("no stale res", res, 65'd0);
    check_val("no stale invalid", 65'(invalid), 65'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
